cfg_tile_target: RTL and testbench
==================================

CFG_TILE_TARGET -- requirements
Module: cfg_tile_target

Interface
REQ-001 SHALL have parameter TILE_ID_W, default 16, meaning width of the tile-coordinate field, formatted {X[7:0],Y[7:0]}.
REQ-002 SHALL have parameter SRAM_AW, default 8, meaning the SRAM word-address width (256 x 16-bit words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  tile stall; SRAM config access is legal only while it is high.
REQ-006 SHALL have port tile_id  input  16  this tile's {X,Y}.
REQ-007 SHALL have port config_config_addr  input  32  {word[31:24], feature[23:16], tile[15:0]}.
REQ-008 SHALL have ports config_config_data  input  32, config_read  input  1, config_write  input  1  for write data, read strobe and write strobe.
REQ-009 SHALL have port read_config_data  output  32  readback; 0 when this tile is not addressed.
REQ-010 SHALL have ports cfg_reg  output  8x32  register file contents, and flush  output  1  equal to cfg_reg[0][9].
REQ-011 SHALL have ports sram_cen, sram_wen  output  1, sram_addr  output  SRAM_AW, sram_wdata  output  16, sram_rdata  input  16  for a synchronous SRAM with 2-cycle read latency.
REQ-012 SHALL have port busy  output  1  high while an SRAM access is in flight.

Function
REQ-013 SHALL treat an access as a hit only when addr[15:0]==tile_id; misses change no state and drive read_config_data=0.
REQ-014 SHALL, on a feature 0x00 write hit, load cfg_reg[addr[26:24]] with config_config_data on that clock edge.
REQ-015 SHALL, on a feature 0x00 read hit, register cfg_reg[addr[26:24]] onto read_config_data 1 cycle after config_read is sampled.
REQ-016 SHALL decode feature 0x01 as SRAM word addr[31:24] and run an FSM IDLE -> WR (1 cycle) -> IDLE for writes, and IDLE -> RD1 -> RD2 -> RESP -> IDLE for reads.
REQ-017 SHALL, in WR, pulse sram_cen=sram_wen=1 for exactly 1 cycle with sram_wdata=data[15:0].
REQ-018 SHALL pulse sram_cen for 1 cycle with sram_wen=0 on a read, and in RESP drive read_config_data={16'h0,sram_rdata}, holding it until the next hit read begins or config_read falls.
REQ-019 SHALL start each new SRAM access only on the rising edge of its strobe, so that a strobe held for multiple cycles causes exactly one access.
REQ-020 SHALL ignore new strobes while busy=1 (FSM not IDLE); the initiator must space accesses at least 4 cycles apart.
REQ-021 SHALL, for a feature 0x01 hit with stall=0, drop the write or return 0 for the read, leave the SRAM untouched, and set cfg_reg[7][0] (sticky illegal-access flag).
REQ-022 SHALL give write priority if config_read and config_write are both asserted; the read is discarded.
REQ-023 SHALL, for an unmapped feature (not 0x00/0x01), produce no write effect and return read data 0.

Reset
REQ-024 SHALL, on reset assertion, immediately force cfg_reg=0, flush=0, read_config_data=0, sram_cen=sram_wen=0, busy=0 and FSM=IDLE.
REQ-025 SHALL abort any in-flight SRAM access on reset, with no later SRAM pulse or readback.

Configuration
REQ-026 SHALL, with macro CFG_TILE_TARGET_SRAM_EN defined, implement feature 0x01 and the FSM as specified above.
REQ-027 SHALL, without CFG_TILE_TARGET_SRAM_EN, treat feature 0x01 as unmapped, tie sram_cen=sram_wen=0, sram_addr/sram_wdata=0 and busy=0, and never set cfg_reg[7][0].

Structure
REQ-028 SHALL take feature codes, the FSM state enum, the register count (8) and the address field-slice constants from shared package cfg_pkg.
REQ-029 SHALL place the SRAM FSM in sub-module cfg_sram_port; address decode and the register file stay in the top module.

Verification
REQ-030 SHALL cover: tile_id=0x0302, write addr 0x00000302 data 0x001C7E00 -> cfg_reg[0]=0x001C7E00, flush=1; write 0x001C0000 -> flush=0 next cycle.
REQ-031 SHALL cover: stall=1, write addr 0x05010302 data 0x0099, then read the same address (strobe held 5 cycles) -> one sram write pulse, read_config_data=0x00000099 at RESP, exactly one read pulse.
REQ-032 SHALL cover: stall=0, SRAM write to 0x05010302 -> sram_cen stays 0, cfg_reg[7][0]=1; SRAM read -> data 0.
REQ-033 SHALL cover: write to addr 0x00000201 while tile_id=0x0302 -> no state change; read of the same address -> 0.
REQ-034 SHALL cover: read issued, reset asserted in RD1 -> all outputs 0 asynchronously, no RESP after release.
REQ-035 SHALL cover: read and write asserted together on reg 3 -> write taken, read_config_data unchanged.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and SRAM FSM state for cfg_tile_target.
package cfg_pkg;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int TILE_LSB  = 0;
  localparam int FEAT_LSB  = 16;
  localparam int FEAT_W    = 8;
  localparam int WORD_LSB  = 24;
  localparam int WORD_W    = 8;
  localparam int FLUSH_BIT = 9;
  localparam int ILL_BIT   = 0;

  localparam logic [FEAT_W-1:0] FEAT_REG  = 8'h00;
  localparam logic [FEAT_W-1:0] FEAT_SRAM = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2,
    S_RESP
  } sram_state_t;
endpackage

// File: rtl/cfg_sram_port.sv
// cfg_sram_port: single-access SRAM sequencer, one write or one
// 2-cycle-latency read per start pulse.
module cfg_sram_port
  import cfg_pkg::*;
#(
  parameter int SRAM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_wr,
  input  logic               start_rd,
  input  logic [SRAM_AW-1:0] addr,
  input  logic [15:0]        wdata,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  output logic               busy,
  output logic               resp_valid
);
  sram_state_t state, state_nxt;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (start_wr || start_rd)) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    sram_cen   = 1'b0;
    sram_wen   = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_wr)      state_nxt = S_WR;
        else if (start_rd) state_nxt = S_RD1;
      end
      S_WR: begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RD1: begin
        sram_cen  = 1'b1;
        state_nxt = S_RD2;
      end
      S_RD2:  state_nxt = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy       = state != S_IDLE;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
endmodule

// File: rtl/cfg_tile_target.sv
// cfg_tile_target: tile config target with 8x32 register file.
// SRAM feature 0x01 enabled by CFG_TILE_TARGET_SRAM_EN.
module cfg_tile_target
  import cfg_pkg::*;
#(
  parameter int TILE_ID_W = 16,
  parameter int SRAM_AW   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [TILE_ID_W-1:0]         tile_id,
  input  logic [31:0]                  config_config_addr,
  input  logic [31:0]                  config_config_data,
  input  logic                         config_read,
  input  logic                         config_write,
  output logic [31:0]                  read_config_data,
  output logic [NUM_REGS-1:0][31:0]    cfg_reg,
  output logic                         flush,
  output logic                         sram_cen,
  output logic                         sram_wen,
  output logic [SRAM_AW-1:0]           sram_addr,
  output logic [15:0]                  sram_wdata,
  input  logic [15:0]                  sram_rdata,
  output logic                         busy
);
  logic                     hit, rd;
  logic [FEAT_W-1:0]        feat;
  logic [REG_IDX_W-1:0]     idx;
  logic [NUM_REGS-1:0][31:0] regs;
  logic [31:0]              rdata_q;
  logic                     read_q;
  logic                     sram_hit, illegal, resp_valid;

  assign hit  = config_config_addr[TILE_LSB +: TILE_ID_W] == tile_id;
  assign feat = config_config_addr[FEAT_LSB +: FEAT_W];
  assign idx  = config_config_addr[WORD_LSB +: REG_IDX_W];
  // a write in the same cycle wins over a read
  assign rd   = config_read && !config_write;

`ifdef CFG_TILE_TARGET_SRAM_EN
  logic write_q;
  logic start_wr, start_rd;

  assign sram_hit = hit && feat == FEAT_SRAM;
  assign illegal  = sram_hit && !stall &&
                    (config_read || config_write);
  assign start_wr = sram_hit && stall && config_write &&
                    !write_q && !busy;
  assign start_rd = sram_hit && stall && rd &&
                    !read_q && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) write_q <= 1'b0;
    else       write_q <= config_write;
  end

  cfg_sram_port #(
    .SRAM_AW(SRAM_AW)
  ) u_sram_port (
    .clk       (clk),
    .reset     (reset),
    .start_wr  (start_wr),
    .start_rd  (start_rd),
    .addr      (config_config_addr[WORD_LSB +: SRAM_AW]),
    .wdata     (config_config_data[15:0]),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .busy      (busy),
    .resp_valid(resp_valid)
  );
`else
  logic unused_ok;

  assign sram_hit   = 1'b0;
  assign illegal    = 1'b0;
  assign resp_valid = 1'b0;
  assign sram_cen   = 1'b0;
  assign sram_wen   = 1'b0;
  assign sram_addr  = '0;
  assign sram_wdata = '0;
  assign busy       = 1'b0;
  assign unused_ok  = ^{stall,
    config_config_addr[31:WORD_LSB+REG_IDX_W]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      if (hit && config_write && feat == FEAT_REG)
        regs[idx] <= config_config_data;
      if (illegal)
        regs[NUM_REGS-1][ILL_BIT] <= 1'b1;
    end
  end

  // SRAM readback sticks until a new hit read or the strobe drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      read_q  <= 1'b0;
    end else begin
      read_q <= config_read;
      if (resp_valid) begin
        rdata_q <= {16'h0, sram_rdata};
      end else if (rd) begin
        if (hit && feat == FEAT_REG)
          rdata_q <= regs[idx];
        else if (!sram_hit || !read_q)
          rdata_q <= '0;
      end else if (read_q && !config_read) begin
        rdata_q <= '0;
      end
    end
  end

  assign read_config_data = resp_valid ?
                            {16'h0, sram_rdata} : rdata_q;
  assign cfg_reg = regs;
  assign flush   = regs[0][FLUSH_BIT];
endmodule

// File: tb/tb_cfg_tile_target.sv
// tb_cfg_tile_target: directed + random checks of cfg_tile_target
// against a register/SRAM reference model and a behavioural SRAM.
module tb_cfg_tile_target;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic [15:0]      tile_id = 16'h0302;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  logic [31:0]      read_config_data;
  logic [7:0][31:0] cfg_reg;
  logic             flush, sram_cen, sram_wen, busy;
  logic [7:0]       sram_addr;
  logic [15:0]      sram_wdata;
  logic [15:0]      sram_rdata = '0;
  logic [15:0]      pipe = '0;
  logic [15:0]      mem [256];
  int               wr_pulses = 0;
  int               rd_pulses = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [31:0]      m_reg [8];

  always #5 clk = ~clk;

  cfg_tile_target dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .tile_id           (tile_id),
    .config_config_addr(addr),
    .config_config_data(wdata),
    .config_read       (rd),
    .config_write      (wr),
    .read_config_data  (read_config_data),
    .cfg_reg           (cfg_reg),
    .flush             (flush),
    .sram_cen          (sram_cen),
    .sram_wen          (sram_wen),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata),
    .busy              (busy)
  );

  // synchronous SRAM, data valid two edges after the enable edge
  always @(posedge clk) begin
    if (sram_cen && sram_wen) begin
      mem[sram_addr] <= sram_wdata;
      wr_pulses <= wr_pulses + 1;
    end
    if (sram_cen && !sram_wen) begin
      pipe <= mem[sram_addr];
      rd_pulses <= rd_pulses + 1;
    end
    sram_rdata <= pipe;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_reg_hit(input logic [31:0] a);
    return a[15:0] == tile_id && a[23:16] == 8'h00;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    if (is_reg_hit(a)) m_reg[int'(a[31:24]) % 8] = d;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (is_reg_hit(a)) return m_reg[int'(a[31:24]) % 8];
    return 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), cfg_reg[i], m_reg[i]);
    chk({tag, "_flush"}, {31'h0, flush}, {31'h0, m_reg[0][9]});
  endtask

  task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd_cyc(input string tag, input logic [31:0] a);
    addr = a; rd = 1'b1;
    tick();
    chk(tag, read_config_data, model_rd(a));
    rd = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [15:0] t;
    logic [7:0]  f;
    t = tile_id;
    if ($urandom_range(0, 3) == 0)
      t = tile_id ^ 16'($urandom_range(1, 65535));
    f = 8'h00;
    if ($urandom_range(0, 4) == 0) f = 8'($urandom_range(2, 255));
    return {8'($urandom()), f, t};
  endfunction

  initial begin
    int wp0, rp0;
    logic [31:0] a, d, old3;
    logic [7:0]  w;
    logic [15:0] sd;

    foreach (m_reg[i]) m_reg[i] = '0;
    repeat (2) tick();
    chk("rst_rdata", read_config_data, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_cen", {31'h0, sram_cen}, 0);
    chk("rst_wen", {31'h0, sram_wen}, 0);
    check_regs("rst");
    reset = 1'b0;
    tick();

    wr_cyc(32'h00000302, 32'h001C7E00);
    check_regs("flush_set");
    chk("flush_on", {31'h0, flush}, 1);
    wr_cyc(32'h00000302, 32'h001C0000);
    chk("flush_off", {31'h0, flush}, 0);

    for (int n = 0; n < 24; n++) begin
      a = rand_addr();
      d = $urandom();
      wr_cyc(a, d);
      if ($urandom_range(0, 1) == 0) a = rand_addr();
      rd_cyc($sformatf("rand_rd%0d", n), a);
    end
    check_regs("rand");

    wr_cyc(32'h00000302, 32'h00000A5C);
    addr = 32'h00000302; rd = 1'b1;
    tick();
    chk("hold_rd_hit", read_config_data, 32'h00000A5C);
    addr = 32'h00000201;
    tick();
    chk("miss_rd", read_config_data, 0);
    rd = 1'b0;
    wr_cyc(32'h00000201, 32'hDEADBEEF);
    check_regs("miss_wr");

    addr = 32'h03000302; rd = 1'b1;
    tick();
    old3 = m_reg[3];
    chk("rw_pre", read_config_data, old3);
    wdata = ~old3; wr = 1'b1;
    tick();
    m_reg[3] = ~old3;
    chk("rw_rdata", read_config_data, old3);
    chk("rw_reg3", cfg_reg[3], ~old3);
    wr = 1'b0; rd = 1'b0;
    tick();

`ifdef CFG_TILE_TARGET_SRAM_EN
    stall = 1'b1;
    wp0 = wr_pulses;
    addr = 32'h05010302; wdata = 32'h00000099; wr = 1'b1;
    tick();
    chk("wr_cen", {31'h0, sram_cen}, 1);
    chk("wr_wen", {31'h0, sram_wen}, 1);
    chk("wr_addr", {24'h0, sram_addr}, 5);
    chk("wr_data", {16'h0, sram_wdata}, 32'h99);
    chk("wr_busy", {31'h0, busy}, 1);
    tick();
    chk("wr_cen_end", {31'h0, sram_cen}, 0);
    wr = 1'b0;
    repeat (3) tick();
    chk("wr_pulses", wr_pulses - wp0, 1);
    chk("wr_mem", {16'h0, mem[5]}, 32'h99);

    rp0 = rd_pulses;
    addr = 32'h05010302; rd = 1'b1;
    tick();
    chk("rd1_cen", {31'h0, sram_cen}, 1);
    chk("rd1_wen", {31'h0, sram_wen}, 0);
    chk("rd1_busy", {31'h0, busy}, 1);
    tick();
    chk("rd2_cen", {31'h0, sram_cen}, 0);
    tick();
    chk("rd_resp", read_config_data, 32'h99);
    tick();
    chk("rd_hold", read_config_data, 32'h99);
    chk("rd_idle", {31'h0, busy}, 0);
    tick();
    chk("rd_hold2", read_config_data, 32'h99);
    rd = 1'b0;
    tick();
    chk("rd_pulses", rd_pulses - rp0, 1);

    rp0 = rd_pulses; wp0 = wr_pulses;
    addr = 32'h05010302; rd = 1'b1;
    tick();
    rd = 1'b0;
    addr = 32'h07010302; wdata = 32'h0000BEEF; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
    chk("busy_resp", read_config_data, 32'h99);
    repeat (3) tick();
    chk("busy_wr_drop", wr_pulses - wp0, 0);
    chk("busy_rd_once", rd_pulses - rp0, 1);

    for (int n = 0; n < 6; n++) begin
      w = 8'($urandom());
      sd = 16'($urandom());
      wp0 = wr_pulses; rp0 = rd_pulses;
      addr = {w, 8'h01, tile_id}; wdata = {16'($urandom()), sd};
      wr = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      wr = 1'b0;
      repeat (4) tick();
      addr = {w, 8'h01, tile_id}; rd = 1'b1;
      tick();
      rd = 1'b0;
      repeat (2) tick();
      chk($sformatf("rnd_resp%0d", n), read_config_data, {16'h0, sd});
      tick();
      chk($sformatf("rnd_hold%0d", n), read_config_data, {16'h0, sd});
      chk($sformatf("rnd_wp%0d", n), wr_pulses - wp0, 1);
      chk($sformatf("rnd_rp%0d", n), rd_pulses - rp0, 1);
    end

    stall = 1'b0;
    wp0 = wr_pulses; rp0 = rd_pulses;
    addr = 32'h05010302; wdata = 32'h00001234; wr = 1'b1;
    tick();
    wr = 1'b0;
    chk("ill_cen", {31'h0, sram_cen}, 0);
    chk("ill_busy", {31'h0, busy}, 0);
    m_reg[7][0] = 1'b1;
    check_regs("ill_wr");
    rd = 1'b1;
    tick();
    chk("ill_rd", read_config_data, 0);
    repeat (3) tick();
    chk("ill_rd_late", read_config_data, 0);
    rd = 1'b0;
    tick();
    chk("ill_no_wr", wr_pulses - wp0, 0);
    chk("ill_no_rd", rd_pulses - rp0, 0);

    stall = 1'b1;
    wr_cyc(32'h00000302, 32'h00000200);
    chk("pre_rst_flush", {31'h0, flush}, 1);
    rp0 = rd_pulses;
    addr = 32'h05010302; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("rst_rd1_cen", {31'h0, sram_cen}, 1);
    #2 reset = 1'b1;
    #1;
    foreach (m_reg[i]) m_reg[i] = '0;
    chk("arst_rdata", read_config_data, 0);
    chk("arst_cen", {31'h0, sram_cen}, 0);
    chk("arst_wen", {31'h0, sram_wen}, 0);
    chk("arst_busy", {31'h0, busy}, 0);
    check_regs("arst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_rdata%0d", i), read_config_data, 0);
    end
    chk("post_rst_rd", rd_pulses - rp0, 0);
`else
    stall = 1'b1;
    wr_cyc(32'h05010302, 32'h00000099);
    chk("nos_cen", {31'h0, sram_cen}, 0);
    chk("nos_wen", {31'h0, sram_wen}, 0);
    chk("nos_busy", {31'h0, busy}, 0);
    chk("nos_addr", {24'h0, sram_addr}, 0);
    chk("nos_wdata", {16'h0, sram_wdata}, 0);
    check_regs("nos_wr");
    addr = 32'h05010302; rd = 1'b1;
    tick();
    chk("nos_rd", read_config_data, 0);
    repeat (3) tick();
    chk("nos_rd_late", read_config_data, 0);
    rd = 1'b0;
    stall = 1'b0;
    wr_cyc(32'h05010302, 32'h00001234);
    check_regs("nos_noflag");
    chk("nos_pulses", wr_pulses + rd_pulses, 0);
`endif

    wr_cyc(32'h00000302, 32'h00000200);
    addr = 32'h00000302; rd = 1'b1;
    tick();
    chk("arst2_pre", read_config_data, 32'h200);
    #2 reset = 1'b1;
    #1;
    foreach (m_reg[i]) m_reg[i] = '0;
    chk("arst2_rdata", read_config_data, 0);
    check_regs("arst2");
    rd = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("arst2_after", read_config_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
